// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - in-order instruction prefetch queue feeding IF/ID
// Optional drop statistics counter enabled by defining IFQ_STATS_EN.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
`ifdef IFQ_STATS_EN
  output logic [15:0] drop_count,
`endif
  output logic [31:0] PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outs;
  logic [CW-1:0] drop;

  logic [CW:0]   credit;
  logic [31:0]   target_pc;
  logic          accept;
  logic          push;
  logic          pop;

  // Requests only go out while every in-flight response is guaranteed a slot.
  assign credit    = {1'b0, count} + {1'b0, outs};
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req  = !Resetn && !redirect && (credit < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign accept    = imem_req && imem_ready;
  assign push      = !Resetn && !redirect && imem_rvalid && (drop == '0);
  assign pop       = inst_valid && !stall;

  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? inst_mem[rd_ptr] : 32'h0;
  assign pc4_out    = inst_valid ? pc4_mem[rd_ptr]  : 32'h0;

  always_ff @(posedge Clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc4_mem[wr_ptr]  <= rsp_pc_q + 32'd4;
    end
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outs     <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the old path and must be dropped.
      pc_q     <= target_pc;
      rsp_pc_q <= target_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      outs     <= outs - CW'(imem_rvalid);
      drop     <= outs - CW'(imem_rvalid);
    end else begin
      if (accept) pc_q <= pc_q + 32'd4;
      if (imem_rvalid) begin
        if (drop != '0) drop <= drop - 1'b1;
        else            rsp_pc_q <= rsp_pc_q + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      outs  <= outs + CW'(accept) - CW'(imem_rvalid);
    end
  end

`ifdef IFQ_STATS_EN
  logic discard;
  assign discard = imem_rvalid && (redirect || (drop != '0));

  always_ff @(posedge Clock) begin
    if (Resetn)
      drop_count <= 16'h0;
    else if (discard && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction prefetch unit that sits directly upstream of the IF/ID pipeline register and feeds it. It issues sequential fetch requests to instruction memory and buffers returned words in a small in-order FIFO. It presents one instruction plus its PC+4 per cycle to the ID stage. It absorbs load-use stalls, and flushes all buffered and in-flight work on a branch or jump redirect.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
- Clock  in  1  single clock; all state updates on rising edge
- Resetn  in  1  reset; synchronous, active-high (1 = reset)
- redirect  in  1  taken branch/jump from ID (pcsource != 0)
- redirect_pc  in  32  new fetch address (bpc or jpc); low 2 bits ignored
- stall  in  1  consumer hold (LOADDEPEN); head not popped
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in order, latency >= 1
- imem_rdata  in  32  response instruction word
- inst_valid  out  1  queue non-empty
- inst_out  out  32  head instruction; 32'h0 (NOP) when empty
- pc4_out  out  32  head address + 4; 32'h0 when empty
- PC  out  32  next fetch address
- drop_count  out  16  (only with IFQ_STATS_EN) responses discarded by redirects, saturating

## Operation
- State: fetch PC, FIFO (rd/wr pointers, count 0..DEPTH), outstanding counter `outs` (0..DEPTH), drop counter `drop` (0..DEPTH).
- Issue: imem_req = !Resetn_active && !redirect && (count + outs < DEPTH). The request is accepted when imem_req && imem_ready. On acceptance: PC += 4 and outs++.
- Response: when imem_rvalid fires, outs--. If drop > 0, then drop-- and the word is discarded. Otherwise the word is pushed with pc4 = its address + 4. Response addresses are tracked by a shadow "response PC" register, advanced by 4 per kept response and loaded on redirect.
- Pop: when inst_valid && !stall, the head is removed.
- Credit rule: the FIFO cannot overflow, so push-at-full is unreachable. Simultaneous push and pop leaves count unchanged.
- Redirect (cycle T):
  - FIFO is emptied at the end of T.
  - PC and response PC are set to {redirect_pc[31:2],2'b00}.
  - drop is set to outs after the T update, i.e. including a request accepted in T. No request is accepted in T, because imem_req is low.
  - A response arriving in T is discarded.
  - Pop in T has no effect.
- Priority: reset > redirect > normal issue/push/pop.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Counters use clog2(DEPTH)+1 bits.

## Timing
- Reset values: PC = RESET_PC, count = outs = drop = 0, inst_valid = 0, inst_out = 0, pc4_out = 0, imem_req = 0 during the reset cycle, drop_count = 0.
- First request: the cycle after Resetn deasserts.
- Latency: response in cycle N is pushed at edge N and is visible on inst_out in N+1. With latency-1 memory, throughput is 1 instruction/cycle when not stalled.
- Outputs are registered or FIFO-head reads. There is no combinational path from imem_rdata to inst_out.
- Redirect: first new request in T+1. First new instruction is no earlier than T+3 with latency-1 memory.
- Reset mid-operation: state is cleared regardless of in-flight responses. Responses arriving after reset to pre-reset requests are the memory's responsibility; the memory is reset with the same Resetn.

## Configuration
- IFQ_STATS_EN defined: drop_count port and counter exist. drop_count increments per discarded response, saturates at 16'hFFFF, and clears on reset.
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset, RESET_PC=0, memory latency 1, ready=1 -> imem_addr 0,4,8,12 on consecutive cycles. inst_out sequence matches memory, with pc4_out 4,8,12,16.
- Hold stall=1 with DEPTH=4 -> imem_req drops once count+outs=4. Release stall -> 4 queued words pop in order, then issue resumes at 16.
- Latency 3, redirect to 0x100 with 3 in flight -> 3 responses discarded (drop_count=3 with IFQ_STATS_EN). First kept word has pc4_out 0x104.
- imem_ready=0 for 5 cycles -> imem_addr and PC stay constant and no pushes occur. Ready=1 -> sequence continues without gaps.
- Redirect in the same cycle as a response and a pop at count=2 -> queue empty next cycle and the response discarded.
- Resetn asserted mid-stream with queue full -> next cycle inst_valid=0, inst_out=0, PC=RESET_PC.
